// File: rtl/iob_cycle.sv
// iob_cycle: Mac-side motherboard I/O bus cycle sequencer.
// Takes one latched FSB I/O request and runs either a 68000 asynchronous cycle
// (nDTACK) or a 6800 synchronous cycle (nVPA/E/nVMA). It drives the latch and
// buffer enables and finishes with a one-cycle IOACK pulse plus a bus-error flag.
// One CLK2X_IOB cycle is one 68000 bus half-state. All outputs are registered.
// Optional feature: define IOB_TIMEOUT_EN to force a bus error after
// TIMEOUT_CYC wait-state cycles. Without it, wait states last indefinitely.
module iob_cycle #(
    parameter int TO_W        = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic CLK2X_IOB,
    input  logic nRESETin,
    input  logic IOREQ,
    input  logic nWE_REQ,
    input  logic nUDS_REQ,
    input  logic nLDS_REQ,
    output logic IOACTV,
    output logic IOACK,
    output logic IOBERR,
    output logic nAS_IOB,
    output logic nUDS_IOB,
    output logic nLDS_IOB,
    output logic nWE_IOB,
    output logic nVMA_IOB,
    input  logic nDTACK_IOB,
    input  logic nVPA_IOB,
    input  logic nBERR_IOB,
    input  logic E_IOB,
    output logic ADoutLE,
    output logic DinLE,
    output logic nDoutOE
);

    typedef enum logic [3:0] {
        IDLE, S0, S1, S2, S3, W, D1, D2, V1, V2, V3, END, REC
    } state_t;

    state_t state_q;

    logic dtackMeta_q, dtackSync_q;
    logic vpaMeta_q, vpaSync_q;
    logic berrMeta_q, berrSync_q;
    logic eMeta_q, eSync_q;

    logic ioactv_q, ioack_q, ioberr_q;
    logic nAS_q, nUDS_q, nLDS_q, nWE_q, nVMA_q;
    logic adoutLE_q, dinLE_q, nDoutOE_q;
    logic udsReq_q, ldsReq_q;
    logic [2:0] eCnt_q;

    logic finish_d, finishErr_d;
    logic toHit;

    // Two-flop synchronisers; the strobes preset high (negated) and E preset low.
    always_ff @(posedge CLK2X_IOB or negedge nRESETin) begin
        if (!nRESETin) begin
            dtackMeta_q <= 1'b1;
            dtackSync_q <= 1'b1;
            vpaMeta_q   <= 1'b1;
            vpaSync_q   <= 1'b1;
            berrMeta_q  <= 1'b1;
            berrSync_q  <= 1'b1;
            eMeta_q     <= 1'b0;
            eSync_q     <= 1'b0;
        end else begin
            dtackMeta_q <= nDTACK_IOB;
            dtackSync_q <= dtackMeta_q;
            vpaMeta_q   <= nVPA_IOB;
            vpaSync_q   <= vpaMeta_q;
            berrMeta_q  <= nBERR_IOB;
            berrSync_q  <= berrMeta_q;
            eMeta_q     <= E_IOB;
            eSync_q     <= eMeta_q;
        end
    end

`ifdef IOB_TIMEOUT_EN
    logic [TO_W-1:0] toCnt_q;
    logic [TO_W-1:0] toCnt_d;

    assign toCnt_d = (toCnt_q == {TO_W{1'b1}}) ? toCnt_q : toCnt_q + TO_W'(1);
    assign toHit   = (toCnt_d == TO_W'(TIMEOUT_CYC));

    // Wait-state counter: cleared on the way into W, saturating while waiting.
    always_ff @(posedge CLK2X_IOB or negedge nRESETin) begin
        if (!nRESETin) begin
            toCnt_q <= '0;
        end else if (state_q == S3) begin
            toCnt_q <= '0;
        end else if (state_q == W || state_q == V1 || state_q == V2 || state_q == V3) begin
            toCnt_q <= toCnt_d;
        end
    end
`else
    // With no timeout the sizing parameters have no effect; they are folded into a
    // tied-off flag so the configuration stays visible on the instance.
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = (TO_W > 0) && (TIMEOUT_CYC > 0);
    assign toHit = 1'b0;
`endif

    // Decide whether this cycle moves into END, and whether it ends in bus error.
    // Priority in the wait states is nBERR, then normal termination, then timeout.
    always_comb begin
        finish_d    = 1'b0;
        finishErr_d = 1'b0;
        case (state_q)
            W: begin
                if (!berrSync_q) begin
                    finish_d    = 1'b1;
                    finishErr_d = 1'b1;
                end else if (dtackSync_q && vpaSync_q && toHit) begin
                    finish_d    = 1'b1;
                    finishErr_d = 1'b1;
                end
            end
            D2: begin
                finish_d = 1'b1;
            end
            V1: begin
                if (!berrSync_q || (eSync_q && toHit)) begin
                    finish_d    = 1'b1;
                    finishErr_d = 1'b1;
                end
            end
            V2: begin
                if (!berrSync_q || (!eSync_q && toHit)) begin
                    finish_d    = 1'b1;
                    finishErr_d = 1'b1;
                end
            end
            V3: begin
                if (!berrSync_q) begin
                    finish_d    = 1'b1;
                    finishErr_d = 1'b1;
                end else if (!eSync_q) begin
                    finish_d = 1'b1;
                end else if (toHit) begin
                    finish_d    = 1'b1;
                    finishErr_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Cycle sequencer; each transition loads the registered outputs of the state entered.
    always_ff @(posedge CLK2X_IOB or negedge nRESETin) begin
        if (!nRESETin) begin
            state_q   <= IDLE;
            ioactv_q  <= 1'b0;
            ioack_q   <= 1'b0;
            ioberr_q  <= 1'b0;
            nAS_q     <= 1'b1;
            nUDS_q    <= 1'b1;
            nLDS_q    <= 1'b1;
            nWE_q     <= 1'b1;
            nVMA_q    <= 1'b1;
            adoutLE_q <= 1'b0;
            dinLE_q   <= 1'b0;
            nDoutOE_q <= 1'b1;
            udsReq_q  <= 1'b1;
            ldsReq_q  <= 1'b1;
            eCnt_q    <= 3'd0;
        end else begin
            adoutLE_q <= 1'b0;
            dinLE_q   <= 1'b0;
            ioack_q   <= 1'b0;
            if (finish_d) begin
                state_q  <= END;
                nAS_q    <= 1'b1;
                nUDS_q   <= 1'b1;
                nLDS_q   <= 1'b1;
                nVMA_q   <= 1'b1;
                ioack_q  <= 1'b1;
                ioberr_q <= finishErr_d;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (IOREQ) begin
                            state_q   <= S0;
                            adoutLE_q <= 1'b1;
                            ioactv_q  <= 1'b1;
                            ioberr_q  <= 1'b0;
                            nWE_q     <= nWE_REQ;
                        end
                    end
                    S0: begin
                        state_q  <= S1;
                        nAS_q    <= 1'b0;
                        udsReq_q <= nUDS_REQ;
                        ldsReq_q <= nLDS_REQ;
                        if (nWE_q) begin
                            nUDS_q <= nUDS_REQ;
                            nLDS_q <= nLDS_REQ;
                        end
                    end
                    S1: begin
                        state_q <= S2;
                        if (!nWE_q) begin
                            nDoutOE_q <= 1'b0;
                        end
                    end
                    S2: begin
                        state_q <= S3;
                        if (!nWE_q) begin
                            nUDS_q <= udsReq_q;
                            nLDS_q <= ldsReq_q;
                        end
                    end
                    S3: begin
                        state_q <= W;
                    end
                    W: begin
                        if (!dtackSync_q) begin
                            state_q <= D1;
                        end else if (!vpaSync_q) begin
                            state_q <= V1;
                        end
                    end
                    D1: begin
                        state_q <= D2;
                        dinLE_q <= nWE_q;
                    end
                    V1: begin
                        if (!eSync_q) begin
                            state_q <= V2;
                            nVMA_q  <= 1'b0;
                        end
                    end
                    V2: begin
                        if (eSync_q) begin
                            state_q <= V3;
                            eCnt_q  <= 3'd1;
                        end
                    end
                    V3: begin
                        if (eCnt_q != 3'd7) begin
                            eCnt_q <= eCnt_q + 3'd1;
                        end
                        dinLE_q <= nWE_q && (eCnt_q == 3'd5);
                    end
                    END: begin
                        state_q   <= REC;
                        ioactv_q  <= 1'b0;
                        ioberr_q  <= 1'b0;
                        nDoutOE_q <= 1'b1;
                        nWE_q     <= 1'b1;
                    end
                    REC: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign IOACTV   = ioactv_q;
    assign IOACK    = ioack_q;
    assign IOBERR   = ioberr_q;
    assign nAS_IOB  = nAS_q;
    assign nUDS_IOB = nUDS_q;
    assign nLDS_IOB = nLDS_q;
    assign nWE_IOB  = nWE_q;
    assign nVMA_IOB = nVMA_q;
    assign ADoutLE  = adoutLE_q;
    assign DinLE    = dinLE_q;
    assign nDoutOE  = nDoutOE_q;

endmodule
